rgb_gray_receiver: RTL and testbench

//   Input stage of the Sobel top: slave side of the rcv_req/rcv_ack pixel port.

---
 rtl/rgb_gray_receiver_if.sv | 19 +
 rtl/rgb_gray_receiver.sv | 135 +++++++++++++
 tb/tb_rgb_gray_receiver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb_gray_receiver_if.sv
// Pixel port between the upstream pixel source (master) and rgb_gray_receiver (slave).
// rcv_req: receiver ready; rcv_ack: pixel_in valid this cycle.
interface rgb_gray_receiver_if;
  logic        rcv_req;
  logic        rcv_ack;
  logic [23:0] pixel_in;

  modport master (
    input  rcv_req,
    output rcv_ack,
    output pixel_in
  );

  modport slave (
    output rcv_req,
    input  rcv_ack,
    input  pixel_in
  );
endinterface

// File: rtl/rgb_gray_receiver.sv
// Sobel input stage: receives one RGB frame, converts to 8-bit luma, writes the gray frame buffer.
// Define GRAY_ROUND_EN for round-to-nearest luma instead of truncation.
module rgb_gray_receiver #(
  parameter int unsigned Width  = 128,
  parameter int unsigned Height = 128,
  parameter int unsigned AddrW  = 14
) (
  input  logic                 clk,
  input  logic                 xrst,
  rgb_gray_receiver_if.slave   pix_if,
  output logic                 mem_we_o,
  output logic [AddrW-1:0]     mem_addr_o,
  output logic [7:0]           mem_wdata_o,
  output logic                 frame_done_o,
  input  logic                 rearm_i
);

  localparam int unsigned PixelNum = Width * Height;

  typedef enum logic [1:0] {StRecv, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic               rcv_req_q, rcv_req_d;
  logic [AddrW-1:0]   count_q, count_d;
  logic               frame_done_q, frame_done_d;

  logic               v1_q;
  logic [15:0]        prod_r_q, prod_g_q, prod_b_q;
  logic [AddrW-1:0]   addr1_q;

  logic               mem_we_q;
  logic [AddrW-1:0]   mem_addr_q;
  logic [7:0]         mem_wdata_q;

  logic               accept;
  logic               last_pix;
  logic [15:0]        sum;

  // rcv_req_q gates acceptance so nothing is taken in the cycle after reset release
  assign accept   = (state_q == StRecv) && rcv_req_q && pix_if.rcv_ack;
  assign last_pix = (count_q == AddrW'(PixelNum - 1));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StRecv: begin
        if (accept) begin
          if (last_pix) begin
            state_d = StDrain;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // Last write is on the bus and nothing is behind it
        if (!v1_q && mem_we_q) begin
          frame_done_d = 1'b1;
          state_d      = StDone;
        end
      end
      StDone: begin
        if (rearm_i) begin
          count_d = '0;
          state_d = StRecv;
        end
      end
      default: state_d = StRecv;
    endcase
    rcv_req_d = (state_d == StRecv);
  end

  always_comb begin
`ifdef GRAY_ROUND_EN
    sum = prod_r_q + prod_g_q + prod_b_q + 16'd128;
`else
    sum = prod_r_q + prod_g_q + prod_b_q;
`endif
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q      <= StRecv;
      rcv_req_q    <= 1'b0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcv_req_q    <= rcv_req_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      v1_q     <= 1'b0;
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      addr1_q  <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        prod_r_q <= 16'd77  * 16'(pix_if.pixel_in[23:16]);
        prod_g_q <= 16'd150 * 16'(pix_if.pixel_in[15:8]);
        prod_b_q <= 16'd29  * 16'(pix_if.pixel_in[7:0]);
        addr1_q  <= count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= v1_q;
      if (v1_q) begin
        mem_addr_q  <= addr1_q;
        mem_wdata_q <= sum[15:8];
      end
    end
  end

  assign pix_if.rcv_req = rcv_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_rgb_gray_receiver.sv
// Directed self-checking bench for rgb_gray_receiver: reset, single pixels, gapped stream,
// mid-frame reset, full frame with frame_done timing, and rearm.
module tb_rgb_gray_receiver;
  localparam int PixelNum = 16384;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        frame_done;
  logic        rearm;

  rgb_gray_receiver_if pix_if ();

  rgb_gray_receiver dut (
    .clk          (clk),
    .xrst         (xrst),
    .pix_if       (pix_if.slave),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .frame_done_o (frame_done),
    .rearm_i      (rearm)
  );

  always #5 clk = ~clk;

  int          nchk = 0;
  int          nfail = 0;
  int          cyc = 0;
  logic [13:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int          done_cnt = 0;
  int          done_cyc = -1;

  // Write/frame_done recorder, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [7:0] gray(logic [23:0] p);
    logic [15:0] s;
    s = 16'd77 * 16'(p[23:16]) + 16'd150 * 16'(p[15:8]) + 16'd29 * 16'(p[7:0]);
`ifdef GRAY_ROUND_EN
    s = s + 16'd128;
`endif
    return s[15:8];
  endfunction

  function automatic logic [23:0] pix(int i);
    logic [31:0] h;
    h = 32'(i) * 32'h9E3779B1;
    return h[31:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] px[5];
  logic [7:0]  ex[5];
  int          base, n, nbad, d0, s0;

  initial begin
    pix_if.rcv_ack  = 1'b0;
    pix_if.pixel_in = '0;
    rearm           = 1'b0;
    px = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF};
`ifdef GRAY_ROUND_EN
    ex = '{8'hFF, 8'h00, 8'h4D, 8'h95, 8'h1D};
`else
    ex = '{8'hFF, 8'h00, 8'h4C, 8'h95, 8'h1C};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rcv_req", 32'(pix_if.rcv_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    xrst = 1'b1;
    step();
    chk("rel_rcv_req", 32'(pix_if.rcv_req), 1);
    chk("rel_mem_we", 32'(mem_we), 0);

    // Single pixels, checked two edges after acceptance
    for (int i = 0; i < 5; i++) begin
      pix_if.rcv_ack  = 1'b1;
      pix_if.pixel_in = px[i];
      step();
      pix_if.rcv_ack = 1'b0;
      step();
      chk("single_we", 32'(mem_we), 1);
      chk($sformatf("single_wdata[%0d]", i), 32'(mem_wdata), 32'(ex[i]));
      chk($sformatf("single_addr[%0d]", i), 32'(mem_addr), 32'(i));
    end

    xrst = 1'b0;
    #2;
    xrst = 1'b1;
    step();
    chk("rel2_rcv_req", 32'(pix_if.rcv_req), 1);

    // Alternating ack: 100 writes, contiguous addresses
    base = wa.size();
    for (int i = 0; i < 200; i++) begin
      pix_if.rcv_ack  = (i % 2 == 0);
      pix_if.pixel_in = pix(i / 2);
      step();
    end
    pix_if.rcv_ack  = 1'b1;
    pix_if.pixel_in = pix(100);
    step();
    pix_if.rcv_ack = 1'b0;
    step();
    chk("inflight_we", 32'(mem_we), 1);
    xrst = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 0);
    chk("midrst_rcv_req", 32'(pix_if.rcv_req), 0);
    n = wa.size() - base;
    chk("alt_count", 32'(n), 100);
    nbad = 0;
    for (int j = 0; j < n; j++) begin
      if (wa[base + j] !== 14'(j) || wd[base + j] !== gray(pix(j))) nbad++;
    end
    chk("alt_addr_data", 32'(nbad), 0);
    #2;
    xrst = 1'b1;
    step();
    chk("rel3_rcv_req", 32'(pix_if.rcv_req), 1);

    // Full back-to-back frame
    base = wa.size();
    d0 = done_cnt;
    pix_if.rcv_ack = 1'b1;
    for (int i = 0; i < PixelNum; i++) begin
      pix_if.pixel_in = pix(i);
      step();
    end
    pix_if.rcv_ack = 1'b0;
    chk("frame_req_low", 32'(pix_if.rcv_req), 0);
    for (int t = 0; t < 8 && done_cnt == d0; t++) step();
    repeat (3) step();
    n = wa.size() - base;
    chk("frame_count", 32'(n), 32'(PixelNum));
    nbad = 0;
    for (int j = 0; j < n; j++) begin
      if (wa[base + j] !== 14'(j) || wd[base + j] !== gray(pix(j))) nbad++;
    end
    chk("frame_addr_data", 32'(nbad), 0);
    chk("frame_done_pulses", 32'(done_cnt - d0), 1);
    if (n > 0) begin
      chk("frame_we_contig", 32'(wc[base + n - 1] - wc[base]), 32'(n - 1));
      chk("frame_done_timing", 32'(done_cyc), 32'(wc[base + n - 1] + 1));
    end

    // Acks ignored after frame_done, then rearm
    s0 = wa.size();
    d0 = done_cnt;
    pix_if.rcv_ack = 1'b1;
    repeat (10) step();
    pix_if.rcv_ack = 1'b0;
    step();
    chk("done_no_writes", 32'(wa.size() - s0), 0);
    chk("done_req_low", 32'(pix_if.rcv_req), 0);
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    chk("rearm_req", 32'(pix_if.rcv_req), 1);
    pix_if.rcv_ack  = 1'b1;
    pix_if.pixel_in = pix(7);
    step();
    pix_if.rcv_ack = 1'b0;
    step();
    chk("rearm_we", 32'(mem_we), 1);
    chk("rearm_addr", 32'(mem_addr), 0);
    chk("rearm_wdata", 32'(mem_wdata), 32'(gray(pix(7))));
    chk("rearm_no_done", 32'(done_cnt - d0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
